baud_div: RTL and testbench
===========================

BAUD_DIV -- requirements
Module: baud_div

Interface
REQ-001 Parameter WIDTH, default 16: width of the divisor, the pending register and the counter.
REQ-002 Parameter DEFAULT_DIV, default 104: period in clk_in cycles after reset (12 MHz / 115200).
REQ-003 Elaboration SHALL fail ($error) if DEFAULT_DIV < 2 or DEFAULT_DIV > 2**WIDTH-1.
REQ-004 clk_in  input  1  system clock; all state on rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-006 en_in  input  1  count enable; counter holds while low.
REQ-007 div_in  input  WIDTH  requested period, in clk_in cycles.
REQ-008 load_in  input  1  single-cycle strobe; captures div_in into the pending register.
REQ-009 sync_in  input  1  phase restart strobe (e.g. on UART start-bit edge).
REQ-010 tick_out  output  1  registered single-cycle pulse, once per period.
REQ-011 half_tick_out  output  1  registered single-cycle pulse at mid-period (sample point).
REQ-012 clk_out  output  1  registered square wave, period P, high floor(P/2) cycles.
REQ-013 err_out  output  1  sticky flag: an illegal divisor (< 2) was loaded.

Function
REQ-014 Internal state: cnt[WIDTH], div_reg[WIDTH] (active period P), pend[WIDTH], pend_v.
REQ-015 en_in=1 and no sync_in: cnt increments; when cnt==P-1 the next value is 0 (wrap).
REQ-016 tick_out SHALL be 1 in the cycle following a cycle with en_in=1, cnt==P-1 and sync_in=0; else 0.
REQ-017 half_tick_out SHALL be 1 in the cycle following a cycle with en_in=1, cnt==floor(P/2)-1 and sync_in=0; else 0.
REQ-018 clk_out SHALL set to 1 on the edge where cnt wraps to 0 and clear to 0 on the edge where cnt becomes floor(P/2).
REQ-019 Odd P: clk_out high floor(P/2) cycles, low ceil(P/2) cycles.
REQ-020 en_in=0: cnt, clk_out and div_reg hold; tick_out and half_tick_out are 0.
REQ-021 load_in=1: pend<=div_in and pend_v<=1; a later load before application overwrites pend.
REQ-022 Loaded value < 2: stored as 2 and err_out set; err_out clears only on reset.
REQ-023 Pending application, glitch-free: div_reg<=pend and pend_v<=0 on the wrap edge, or on any edge with en_in=0 and pend_v=1.
REQ-024 Load and wrap in the same cycle: the value loaded that cycle is NOT applied; it applies at the next wrap.
REQ-025 sync_in=1, regardless of en_in: next cnt=0 and clk_out=1; no tick_out or half_tick_out results from that cycle.
REQ-026 sync_in with pend_v=1 applies pend at that edge.
REQ-027 sync_in and load_in in the same cycle: div_in is applied directly as div_reg (clamped per REQ-022) and pend_v<=0.
REQ-028 sync_in has priority over the wrap and the half-point in the same cycle.
REQ-029 Counter arithmetic is unsigned WIDTH-bit; cnt SHALL never exceed P-1.
REQ-030 The counter never observes a mix of old and new P within one period.
REQ-031 Latency from sync_in: first half_tick_out floor(P/2) cycles after the sync edge; first tick_out P cycles after it (en_in held 1).

Reset
REQ-032 rst_n_in low asynchronously forces: cnt=0, div_reg=DEFAULT_DIV, pend=0, pend_v=0.
REQ-033 Outputs during reset: tick_out=0, half_tick_out=0, clk_out=0, err_out=0.
REQ-034 Reset mid-period or with a load pending discards the pending value.
REQ-035 Counting starts on the first rising edge after release with en_in=1; clk_out first rises at the first wrap.

Verification
REQ-036 Free-run, defaults, en_in=1 for 1000 cycles: tick_out every 104 cycles; half_tick_out 52 cycles after each tick; clk_out 52 high / 52 low.
REQ-037 P=5 via load while en_in=0: tick period 5; half_tick_out at cnt 1; clk_out 2 high / 3 low.
REQ-038 Load div_in=10 at cnt=40 of P=104: current period completes at 104; following periods are 10; tick spacing 104 then 10.
REQ-039 Load div_in=1, then div_in=0: P becomes 2; err_out=1 and stays 1 through later legal loads until reset.
REQ-040 sync_in at cnt=30 of P=104, with simultaneous load_in div_in=20: no tick that cycle; clk_out=1 next cycle; half_tick_out 10 cycles later; tick_out 20 cycles later.
REQ-041 Asserting rst_n_in low mid-period with pend_v=1: all outputs 0 immediately; after release, P=104 and the pending value is never applied.

Source files
------------

// File: rtl/baud_div_if.sv
// Control and status bundle of the baud-rate divider: enable, divisor load,
// phase restart, and the registered tick / clock / error outputs.
interface baud_div_if #(
   parameter int WIDTH = 16
);
   logic             en_in;
   logic [WIDTH-1:0] div_in;
   logic             load_in;
   logic             sync_in;
   logic             tick_out;
   logic             half_tick_out;
   logic             clk_out;
   logic             err_out;

   modport master (
      output en_in, div_in, load_in, sync_in,
      input  tick_out, half_tick_out, clk_out, err_out
   );

   modport slave (
      input  en_in, div_in, load_in, sync_in,
      output tick_out, half_tick_out, clk_out, err_out
   );
endinterface

// File: rtl/baud_div.sv
// Programmable baud-rate divider: period tick, mid-period sample tick and a
// square clock, with glitch-free divisor reload and phase restart.
module baud_div #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 104
) (
   input  logic      clk_in,
   input  logic      rst_n_in,
   baud_div_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   generate
      if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
         $error("baud_div: DEFAULT_DIV %0d out of range for WIDTH %0d", DEFAULT_DIV, WIDTH);
      end
   endgenerate

   // A period shorter than two cycles cannot hold both ticks, so it saturates to 2.
   function automatic logic [WIDTH-1:0] sat_div(input logic [WIDTH-1:0] v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] div_reg, div_nxt;
   logic [WIDTH-1:0] pend, pend_nxt;
   logic             pend_v, pend_v_nxt;
   logic             tick_q, tick_nxt;
   logic             half_q, half_nxt;
   logic             clk_q, clk_nxt;
   logic             err_q, err_nxt;

   logic [WIDTH-1:0] half_p;
   logic [WIDTH-1:0] cnt_inc;
   logic             wrap;
   logic             at_half;
   logic             apply;

   assign half_p  = div_reg >> 1;
   assign cnt_inc = cnt + ONE;
   assign wrap    = (cnt == div_reg - ONE);
   assign at_half = (cnt == half_p - ONE);
   assign apply   = pend_v && (!bus.en_in || wrap);

   always_comb begin
      cnt_nxt    = cnt;
      div_nxt    = div_reg;
      pend_nxt   = pend;
      pend_v_nxt = pend_v;
      clk_nxt    = clk_q;
      tick_nxt   = 1'b0;
      half_nxt   = 1'b0;
      err_nxt    = err_q | (bus.load_in && (bus.div_in < MIN_DIV));

      if (bus.sync_in) begin
         // Phase restart overrides wrap and half-point; a same-cycle load goes live at once.
         cnt_nxt    = '0;
         clk_nxt    = 1'b1;
         pend_v_nxt = 1'b0;
         if (bus.load_in) begin
            div_nxt = sat_div(bus.div_in);
         end else if (pend_v) begin
            div_nxt = pend;
         end
      end else begin
         if (bus.en_in) begin
            tick_nxt = wrap;
            half_nxt = at_half;
            if (wrap) begin
               cnt_nxt = '0;
               clk_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == half_p) begin
                  clk_nxt = 1'b0;
               end
            end
         end

         if (apply) begin
            div_nxt    = pend;
            pend_v_nxt = 1'b0;
            // An idle reload to a shorter period must not leave the counter beyond it.
            if (!bus.en_in && (cnt >= pend)) begin
               cnt_nxt = '0;
            end
         end

         // A load landing on the wrap edge waits for the following wrap.
         if (bus.load_in) begin
            pend_nxt   = sat_div(bus.div_in);
            pend_v_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt     <= '0;
         div_reg <= RST_DIV;
         pend    <= '0;
         pend_v  <= 1'b0;
         tick_q  <= 1'b0;
         half_q  <= 1'b0;
         clk_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_reg <= div_nxt;
         pend    <= pend_nxt;
         pend_v  <= pend_v_nxt;
         tick_q  <= tick_nxt;
         half_q  <= half_nxt;
         clk_q   <= clk_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.tick_out      = tick_q;
   assign bus.half_tick_out = half_q;
   assign bus.clk_out       = clk_q;
   assign bus.err_out       = err_q;
endmodule

// File: tb/tb_baud_div.sv
// Bench for baud_div: directed scenarios plus randomized traffic, every cycle
// compared against a period/phase reference model.
module tb_baud_div;
   localparam int WIDTH = 16;
   localparam int DEF   = 104;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;

   baud_div_if #(.WIDTH(WIDTH)) bus ();

   baud_div #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: position in period, active period, pending period.
   int m_cnt, m_p, m_pend;
   bit m_pv, m_clk, m_err, e_tick, e_half;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_p = DEF; m_pend = 0; m_pv = 0;
      m_clk = 0; m_err = 0; e_tick = 0; e_half = 0;
   endtask

   task automatic model_step(input bit en, input bit load, input bit sync, input int div);
      int lv;
      int old_pend;
      bit old_pv;
      lv = (div < 2) ? 2 : div;
      if (load && div < 2) m_err = 1;
      e_tick = 0;
      e_half = 0;
      if (sync) begin
         if (load) m_p = lv;
         else if (m_pv) m_p = m_pend;
         m_pv = 0; m_cnt = 0; m_clk = 1;
      end else begin
         old_pv = m_pv;
         old_pend = m_pend;
         if (en) begin
            e_tick = (m_cnt == m_p - 1);
            e_half = (m_cnt == m_p / 2 - 1);
            if (e_tick) begin
               m_cnt = 0; m_clk = 1;
               if (old_pv) begin m_p = old_pend; m_pv = 0; end
            end else begin
               m_cnt++;
               if (m_cnt == m_p / 2) m_clk = 0;
            end
         end else if (old_pv) begin
            m_p = old_pend; m_pv = 0;
            if (m_cnt >= m_p) m_cnt = 0;
         end
         if (load) begin m_pend = lv; m_pv = 1; end
      end
   endtask

   task automatic cycle();
      @(posedge clk_in);
      model_step(bus.en_in, bus.load_in, bus.sync_in, int'(bus.div_in));
      #1;
      chk("tick", bus.tick_out, e_tick);
      chk("half_tick", bus.half_tick_out, e_half);
      chk("clk_out", bus.clk_out, m_clk);
      chk("err", bus.err_out, m_err);
      bus.load_in = 1'b0;
      bus.sync_in = 1'b0;
   endtask

   task automatic load_div(input int d);
      bus.div_in  = WIDTH'(d);
      bus.load_in = 1'b1;
      cycle();
   endtask

   // Runs ncyc cycles and checks tick spacing, half-tick offset and clk_out duty.
   task automatic measure(input int ncyc, input int p_exp, input int half_exp,
                          input int hi_exp, output int first);
      int t_prev = -1;
      int hi = 0;
      first = -1;
      for (int i = 1; i <= ncyc; i++) begin
         cycle();
         if (bus.half_tick_out && t_prev >= 0) chk("half_pos", i - t_prev, half_exp);
         if (bus.tick_out) begin
            if (t_prev >= 0) begin
               chk("tick_gap", i - t_prev, p_exp);
               chk("clk_high", hi, hi_exp);
            end else begin
               first = i;
            end
            t_prev = i;
            hi = 0;
         end
         if (bus.clk_out) hi++;
      end
      chk("tick_seen", (first > 0), 1);
   endtask

   task automatic run_until(input bit want_half, input int maxc, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(want_half ? bus.half_tick_out : bus.tick_out) && n < maxc);
   endtask

   task automatic async_reset();
      #2 rst_n_in = 1'b0;
      model_reset();
      #1;
      chk("rst_tick", bus.tick_out, 0);
      chk("rst_half", bus.half_tick_out, 0);
      chk("rst_clk", bus.clk_out, 0);
      chk("rst_err", bus.err_out, 0);
      repeat (2) @(posedge clk_in);
      #2 rst_n_in = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int first;
      int n;
      bus.en_in   = 1'b0;
      bus.div_in  = '0;
      bus.load_in = 1'b0;
      bus.sync_in = 1'b0;
      model_reset();

      // Held in reset across a few edges, then released between edges.
      #12;
      chk("init_tick", bus.tick_out, 0);
      chk("init_half", bus.half_tick_out, 0);
      chk("init_clk", bus.clk_out, 0);
      chk("init_err", bus.err_out, 0);
      #11 rst_n_in = 1'b1;

      // Free run with the default period.
      bus.en_in = 1'b1;
      measure(1000, 104, 52, 52, first);
      chk("first_tick", first, 104);

      // Period 5 loaded while idle.
      bus.en_in = 1'b0;
      load_div(5);
      cycle();
      bus.en_in = 1'b1;
      measure(40, 5, 2, 2, first);

      // Illegal divisors saturate to 2 and latch the error flag.
      bus.en_in = 1'b0;
      load_div(1);
      chk("err_after_1", bus.err_out, 1);
      load_div(0);
      cycle();
      bus.en_in = 1'b1;
      measure(20, 2, 1, 1, first);
      bus.en_in = 1'b0;
      load_div(50);
      cycle();
      chk("err_sticky", bus.err_out, 1);

      // Load mid-period: current 104 period completes, then 10.
      load_div(104);
      cycle();
      bus.sync_in = 1'b1;
      cycle();
      bus.en_in = 1'b1;
      repeat (40) cycle();
      load_div(10);
      run_until(1'b0, 200, n);
      chk("tick_after_load", n, 63);
      run_until(1'b0, 50, n);
      chk("tick_gap_new1", n, 10);
      run_until(1'b0, 50, n);
      chk("tick_gap_new2", n, 10);

      // Sync with simultaneous load at cnt 30.
      bus.en_in = 1'b0;
      load_div(104);
      cycle();
      bus.en_in = 1'b1;
      bus.sync_in = 1'b1;
      cycle();
      repeat (30) cycle();
      bus.sync_in = 1'b1;
      load_div(20);
      chk("sync_no_tick", bus.tick_out, 0);
      chk("sync_clk_high", bus.clk_out, 1);
      run_until(1'b1, 50, n);
      chk("sync_to_half", n, 10);
      run_until(1'b0, 50, n);
      chk("half_to_tick", n, 10);

      // Reset with a load pending discards it.
      load_div(50);
      repeat (3) cycle();
      async_reset();
      measure(320, 104, 52, 52, first);
      chk("post_rst_first_tick", first, 104);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         bus.en_in   = ($urandom_range(7) != 0);
         bus.load_in = ($urandom_range(39) == 0);
         bus.div_in  = WIDTH'($urandom_range(23));
         bus.sync_in = ($urandom_range(59) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
